// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, reads instruction words over Wishbone-classic, and feeds decode through a registered slot plus a one-entry skid buffer.
// Optional macro FETCH_MISALIGN_TRAP_EN: trap misaligned jump targets instead of silently aligning them.

package constants;
    localparam logic [31:0] RESET_ADDRESS = 32'h0000_0000;
endpackage

package pipeline_status;
    typedef enum logic [1:0] {
        VALID            = 2'd0,
        BUBBLE           = 2'd1,
        FETCH_MISALIGNED = 2'd2
    } forwards_t;

    typedef enum logic [1:0] {
        READY = 2'd0,
        STALL = 2'd1,
        JUMP  = 2'd2
    } backwards_t;
endpackage

module fetch_stage (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         wb_cyc_out,
    output logic                         wb_stb_out,
    output logic [31:0]                  wb_adr_out,
    input  logic [31:0]                  wb_dat_in,
    input  logic                         wb_ack_in,
    input  logic                         wb_err_in,
    output logic [31:0]                  instruction_reg_out,
    output logic [31:0]                  program_counter_reg_out,
    output pipeline_status::forwards_t   status_forwards_out,
    input  pipeline_status::backwards_t  status_backwards_in,
    input  logic [31:0]                  jump_address_backwards_in
);
    import pipeline_status::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2,
        S_IDLE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] adr_q, adr_d;
    logic        cyc_q, cyc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] slot_pc_q, slot_pc_d;
    forwards_t   status_q, status_d;
    logic [31:0] buf_word_q, buf_word_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        trap_pending_q, trap_pending_d;

    logic        consumed;
    logic        jump;
    logic        bus_done;
    logic [31:0] bus_word;
    logic        slot_free;
    logic [31:0] jump_target;
    logic        jump_misaligned;

    // A late ack after reset or in HOLD/IDLE is ignored because no cycle is open.
    assign bus_done  = cyc_q && (wb_ack_in || wb_err_in);
    assign bus_word  = wb_err_in ? 32'h0000_0000 : wb_dat_in;
    assign consumed  = (status_backwards_in == READY);
    assign jump      = (status_backwards_in == JUMP);
    assign slot_free = (status_q != VALID) || consumed;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign jump_target     = jump_address_backwards_in;
    assign jump_misaligned = |jump_address_backwards_in[1:0];
`else
    assign jump_target     = jump_address_backwards_in & ~32'h3;
    assign jump_misaligned = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block leaves a signal unassigned and infers a latch.
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        slot_pc_d      = slot_pc_q;
        status_d       = status_q;
        buf_word_d     = buf_word_q;
        buf_pc_d       = buf_pc_q;
        trap_pending_d = trap_pending_q;

        if (jump) begin
            status_d = BUBBLE;
            pc_d     = jump_target;
            case (state_q)
                S_FETCH: state_d = (cyc_q && !bus_done) ? S_FLUSH : S_FETCH;
                S_FLUSH: state_d = S_FLUSH;
                default: state_d = S_FETCH;
            endcase
            trap_pending_d = 1'b0;
            if (jump_misaligned) begin
                instr_d   = NOP;
                slot_pc_d = jump_target;
                status_d  = FETCH_MISALIGNED;
                // An outstanding transfer must still complete before idling.
                if (state_d == S_FLUSH) begin
                    trap_pending_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (bus_done) begin
                        if (slot_free) begin
                            instr_d   = bus_word;
                            slot_pc_d = pc_q;
                            status_d  = VALID;
                        end else begin
                            buf_word_d = bus_word;
                            buf_pc_d   = pc_q;
                            state_d    = S_HOLD;
                        end
                        pc_d = pc_q + 32'd4;
                    end else if (consumed) begin
                        status_d = BUBBLE;
                    end
                end
                S_HOLD: begin
                    if (consumed) begin
                        instr_d   = buf_word_q;
                        slot_pc_d = buf_pc_q;
                        status_d  = VALID;
                        state_d   = S_FETCH;
                    end
                end
                S_FLUSH: begin
                    if (consumed) begin
                        status_d = BUBBLE;
                    end
                    if (bus_done) begin
                        state_d        = trap_pending_q ? S_IDLE : S_FETCH;
                        trap_pending_d = 1'b0;
                    end
                end
                default: begin
                    if (consumed) begin
                        status_d = BUBBLE;
                    end
                end
            endcase
        end

        cyc_d = (state_d == S_FETCH) || (state_d == S_FLUSH);
        // The bus address stays on the stale request until FLUSH sees its ack.
        adr_d = (state_d == S_FLUSH) ? adr_q : pc_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_FETCH;
            pc_q           <= constants::RESET_ADDRESS;
            adr_q          <= constants::RESET_ADDRESS;
            cyc_q          <= 1'b0;
            instr_q        <= NOP;
            slot_pc_q      <= constants::RESET_ADDRESS;
            status_q       <= BUBBLE;
            buf_word_q     <= 32'h0000_0000;
            buf_pc_q       <= 32'h0000_0000;
            trap_pending_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values computed above.
            state_q        <= state_d;
            pc_q           <= pc_d;
            adr_q          <= adr_d;
            cyc_q          <= cyc_d;
            instr_q        <= instr_d;
            slot_pc_q      <= slot_pc_d;
            status_q       <= status_d;
            buf_word_q     <= buf_word_d;
            buf_pc_q       <= buf_pc_d;
            trap_pending_q <= trap_pending_d;
        end
    end

    assign wb_cyc_out              = cyc_q;
    assign wb_stb_out              = cyc_q;
    assign wb_adr_out              = adr_q;
    assign instruction_reg_out     = instr_q;
    assign program_counter_reg_out = slot_pc_q;
    assign status_forwards_out     = status_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a combinational memory answers on the bus, and each step checks hand-computed outputs.

module tb_fetch_stage;
    import pipeline_status::*;

    localparam logic [31:0] RA  = constants::RESET_ADDRESS;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic                 clk;
    logic                 rst;
    logic                 wb_cyc_out;
    logic                 wb_stb_out;
    logic [31:0]          wb_adr_out;
    logic [31:0]          wb_dat_in;
    logic                 wb_ack_in;
    logic                 wb_err_in;
    logic [31:0]          instruction_reg_out;
    logic [31:0]          program_counter_reg_out;
    forwards_t            status_forwards_out;
    backwards_t           status_backwards_in;
    logic [31:0]          jump_address_backwards_in;

    logic ack_en;
    logic err_en;
    int   n_checks;
    int   n_fail;

    fetch_stage dut (
        .clk                       (clk),
        .rst                       (rst),
        .wb_cyc_out                (wb_cyc_out),
        .wb_stb_out                (wb_stb_out),
        .wb_adr_out                (wb_adr_out),
        .wb_dat_in                 (wb_dat_in),
        .wb_ack_in                 (wb_ack_in),
        .wb_err_in                 (wb_err_in),
        .instruction_reg_out       (instruction_reg_out),
        .program_counter_reg_out   (program_counter_reg_out),
        .status_forwards_out       (status_forwards_out),
        .status_backwards_in       (status_backwards_in),
        .jump_address_backwards_in (jump_address_backwards_in)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign wb_dat_in = mem_word(wb_adr_out);
    assign wb_ack_in = wb_cyc_out & ack_en & ~err_en;
    assign wb_err_in = wb_cyc_out & err_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_slot(input string tag, input logic [31:0] instr,
                              input logic [31:0] pc, input forwards_t st);
        check({tag, ".instr"}, instruction_reg_out, instr);
        check({tag, ".pc"}, program_counter_reg_out, pc);
        check({tag, ".status"}, 32'(status_forwards_out), 32'(st));
    endtask

    task automatic check_bus(input string tag, input logic cyc, input logic [31:0] adr);
        check({tag, ".cyc"}, 32'(wb_cyc_out), 32'(cyc));
        check({tag, ".stb"}, 32'(wb_stb_out), 32'(cyc));
        if (cyc) check({tag, ".adr"}, wb_adr_out, adr);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        ack_en = 1'b1;
        err_en = 1'b0;
        status_backwards_in = READY;
        jump_address_backwards_in = 32'h0;

        // Reset state
        step();
        step();
        check_slot("reset", NOP, RA, BUBBLE);
        check_bus("reset", 1'b0, RA);
        check("reset.adr", wb_adr_out, RA);
        rst = 1'b0;

        // Streaming with same-cycle ack
        step();
        check_bus("first_req", 1'b1, RA);
        check("first_req.status", 32'(status_forwards_out), 32'(BUBBLE));
        step();
        check_slot("stream0", mem_word(RA), RA, VALID);
        check_bus("stream0", 1'b1, RA + 32'd4);
        step();
        check_slot("stream1", mem_word(RA + 32'd4), RA + 32'd4, VALID);
        check_bus("stream1", 1'b1, RA + 32'd8);
        step();
        check_slot("stream2", mem_word(RA + 32'd8), RA + 32'd8, VALID);
        check_bus("stream2", 1'b1, RA + 32'hC);

        // STALL for three cycles: one word goes to the skid buffer, then the bus idles
        status_backwards_in = STALL;
        step();
        check_slot("stall1", mem_word(RA + 32'd8), RA + 32'd8, VALID);
        check_bus("stall1", 1'b0, 32'h0);
        step();
        check_slot("stall2", mem_word(RA + 32'd8), RA + 32'd8, VALID);
        check_bus("stall2", 1'b0, 32'h0);
        step();
        check_slot("stall3", mem_word(RA + 32'd8), RA + 32'd8, VALID);
        check_bus("stall3", 1'b0, 32'h0);
        status_backwards_in = READY;
        step();
        check_slot("drain_buf", mem_word(RA + 32'hC), RA + 32'hC, VALID);
        check_bus("drain_buf", 1'b1, RA + 32'h10);
        step();
        check_slot("resume", mem_word(RA + 32'h10), RA + 32'h10, VALID);
        check_bus("resume", 1'b1, RA + 32'h14);

        // JUMP while the ack is delayed
        ack_en = 1'b0;
        step();
        check("wait.status", 32'(status_forwards_out), 32'(BUBBLE));
        check_bus("wait", 1'b1, RA + 32'h14);
        status_backwards_in = JUMP;
        jump_address_backwards_in = 32'h0000_0100;
        step();
        check("flush1.status", 32'(status_forwards_out), 32'(BUBBLE));
        check_bus("flush1", 1'b1, RA + 32'h14);
        status_backwards_in = READY;
        step();
        check("flush2.status", 32'(status_forwards_out), 32'(BUBBLE));
        check_bus("flush2", 1'b1, RA + 32'h14);
        ack_en = 1'b1;
        step();
        check("flush_done.status", 32'(status_forwards_out), 32'(BUBBLE));
        check_bus("flush_done", 1'b1, 32'h0000_0100);
        step();
        check_slot("jump_word", mem_word(32'h100), 32'h100, VALID);
        check_bus("jump_word", 1'b1, 32'h104);

        // JUMP with ack this cycle, then bus error at the top of the address space
        status_backwards_in = JUMP;
        jump_address_backwards_in = 32'hFFFF_FFFC;
        step();
        check("top.status", 32'(status_forwards_out), 32'(BUBBLE));
        check_bus("top", 1'b1, 32'hFFFF_FFFC);
        status_backwards_in = READY;
        err_en = 1'b1;
        step();
        check_slot("err", 32'h0000_0000, 32'hFFFF_FFFC, VALID);
        check_bus("wrap", 1'b1, 32'h0000_0000);
        err_en = 1'b0;
        step();
        check_slot("after_wrap", mem_word(32'h0), 32'h0, VALID);
        check_bus("after_wrap", 1'b1, 32'h4);

        // Misaligned JUMP
        status_backwards_in = JUMP;
        jump_address_backwards_in = 32'h0000_0102;
        step();
`ifdef FETCH_MISALIGN_TRAP_EN
        check_slot("misalign", NOP, 32'h102, FETCH_MISALIGNED);
        check_bus("misalign", 1'b0, 32'h0);
`else
        check("misalign.status", 32'(status_forwards_out), 32'(BUBBLE));
        check_bus("misalign", 1'b1, 32'h100);
`endif
        status_backwards_in = READY;
        step();
`ifdef FETCH_MISALIGN_TRAP_EN
        check("trap_idle.status", 32'(status_forwards_out), 32'(BUBBLE));
        check_bus("trap_idle", 1'b0, 32'h0);
`else
        check_slot("aligned", mem_word(32'h100), 32'h100, VALID);
        check_bus("aligned", 1'b1, 32'h104);
`endif
        status_backwards_in = JUMP;
        jump_address_backwards_in = 32'h0000_0200;
        step();
        check("rejump.status", 32'(status_forwards_out), 32'(BUBBLE));
        check_bus("rejump", 1'b1, 32'h200);
        status_backwards_in = READY;
        step();
        check_slot("rejump_word", mem_word(32'h200), 32'h200, VALID);

        // Enter HOLD, then assert reset between clock edges
        status_backwards_in = STALL;
        step();
        check_bus("hold", 1'b0, 32'h0);
        check_slot("hold", mem_word(32'h200), 32'h200, VALID);
        #2;
        rst = 1'b1;
        #1;
        check_slot("async_rst", NOP, RA, BUBBLE);
        check_bus("async_rst", 1'b0, 32'h0);
        check("async_rst.adr", wb_adr_out, RA);
        status_backwards_in = READY;
        step();
        check_bus("in_rst", 1'b0, 32'h0);
        rst = 1'b0;
        step();
        check_bus("rst_restart", 1'b1, RA);
        step();
        check_slot("rst_restart", mem_word(RA), RA, VALID);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
